// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Slice width, FSM states and counter sizing.
package nibble_serial_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_if.sv
// Start/busy/done handshake and operand/result bus
// between a controller and the nibble-serial subtractor.
interface nibble_serial_sub_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/nibble_serial_sub_bla4.sv
// 4-bit borrow-lookahead subtractor slice: d = a - b - bi.
// Purely combinational; bo is the borrow out of bit 3.
module bla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Every borrow is flattened from g/p and bi, no ripple.
  assign c[0] = bi;
  assign c[1] = g[0]
              | (p[0] & c[0]);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (&p & c[0]);

  assign d  = a ^ b ^ c[3:0];
  assign bo = c[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor: a - b - bin, one nibble per clock,
// LSB slice first, through a single shared bla4 slice.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  nibble_serial_sub_if.slave io
);

  import nibble_serial_sub_pkg::*;

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = cnt_w(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_w;
  logic [WIDTH-1:0]   b_w;
  logic               brw;
  logic [SLICE_W-1:0] wd   [NSLICE];
  logic [SLICE_W-1:0] a_sl [NSLICE];
  logic [SLICE_W-1:0] b_sl [NSLICE];

  logic [SLICE_W-1:0] d_s;
  logic               bo_s;
  logic [WIDTH-1:0]   diff_full;
  logic               ovf_full;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               ovf_q;

  for (genvar k = 0; k < NSLICE; k++) begin : g_sl
    assign a_sl[k] = a_w[k*SLICE_W +: SLICE_W];
    assign b_sl[k] = b_w[k*SLICE_W +: SLICE_W];
  end

  bla4 u_bla4 (
    .a  (a_sl[cnt]),
    .b  (b_sl[cnt]),
    .bi (brw),
    .d  (d_s),
    .bo (bo_s)
  );

  // Stored slices plus the one being resolved this cycle.
  always_comb begin
    diff_full = '0;
    for (int k = 0; k < NSLICE; k++) begin
      diff_full[k*SLICE_W +: SLICE_W] =
        (cnt == CW'(k)) ? d_s : wd[k];
    end
  end

  assign ovf_full =
    (a_w[WIDTH-1] != b_w[WIDTH-1]) &&
    (diff_full[WIDTH-1] != a_w[WIDTH-1]);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (io.start) state_nx = RUN;
      RUN:  if (cnt == LAST) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_w    <= '0;
      b_w    <= '0;
      brw    <= 1'b0;
      wd     <= '{default: '0};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io.start) begin
            a_w    <= io.a;
            b_w    <= io.b;
            brw    <= io.bin;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          wd[cnt] <= d_s;
          brw     <= bo_s;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q <= diff_full;
            bout_q <= bo_s;
            ovf_q  <= ovf_full;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=16)
// against an arithmetic reference model.
module tb_nibble_serial_sub;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [W+1:0] prev_exp;

  nibble_serial_sub_if #(.WIDTH(W)) bus ();

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {bout, ovf, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bin
  );
    int unsigned av, bv, bi;
    logic [W-1:0] d;
    logic bo, ov;
    av = a;
    bv = b;
    bi = bin;
    d  = W'(av - bv - bi);
    bo = av < (bv + bi);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {bo, ov, d};
  endfunction

  // Issue one op from idle; returns outputs, latency, busy cycles.
  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W+1:0] got,
    output int           lat,
    output int           busy_cyc
  );
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    lat       = 1;
    busy_cyc  = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    got = {bus.bout, bus.ovf, bus.diff};
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0",
               {bus.busy, bus.done, bus.bout, bus.ovf, bus.diff});
    end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{16'h1234, 16'h0000, 16'h0005,
                             16'h8000, 16'h7FFF};
    logic [W-1:0] tb_ [5] = '{16'h0234, 16'h0001, 16'h0005,
                              16'h0001, 16'hFFFF};
    logic         tbin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W+1:0] want [5] = '{{2'b00, 16'h1000},
                               {2'b10, 16'hFFFF},
                               {2'b10, 16'hFFFF},
                               {2'b01, 16'h7FFF},
                               {2'b11, 16'h8000}};
    logic [W+1:0] got, mdl;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb_[i], tbin[i], got, lat, bc);
      mdl = model(ta[i], tb_[i], tbin[i]);
      checks++;
      if (got !== want[i] || mdl !== want[i]) begin
        errors++;
        $display("FAIL directed_%0d got=%h want=%h", i, got, want[i]);
      end
      checks++;
      if (lat !== 5 || bc !== 4) begin
        errors++;
        $display("FAIL directed_lat_%0d lat=%0d busy=%0d want 5/4",
                 i, lat, bc);
      end
      prev_exp = want[i];
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle done=%b busy=%b want 0/0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qa [20];
    logic [W-1:0] qb [20];
    logic         qc [20];
    logic [W+1:0] exp_v;
    for (int j = 0; j < 20; j++) begin
      qa[j] = W'($urandom);
      qb[j] = W'($urandom);
      qc[j] = 1'($urandom);
      bus.a     = qa[j];
      bus.b     = qb[j];
      bus.bin   = qc[j];
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (j % 5 == 4) begin
        exp_v = model(qa[j-4], qb[j-4], qc[j-4]);
        checks++;
        if (bus.done !== 1'b1 ||
            {bus.bout, bus.ovf, bus.diff} !== exp_v) begin
          errors++;
          $display("FAIL b2b_done_%0d done=%b got=%h want=%h", j,
                   bus.done, {bus.bout, bus.ovf, bus.diff}, exp_v);
        end
        prev_exp = exp_v;
      end else begin
        checks++;
        if (bus.done !== 1'b0 ||
            {bus.bout, bus.ovf, bus.diff} !== prev_exp) begin
          errors++;
          $display("FAIL b2b_hold_%0d done=%b got=%h want=%h", j,
                   bus.done, {bus.bout, bus.ovf, bus.diff}, prev_exp);
        end
      end
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    logic [W+1:0] got;
    int lat, bc;
    int seen;
    bus.a     = 16'h1234;
    bus.b     = 16'h0234;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== '0) begin
      errors++;
      $display("FAIL abort_zero got=%h want=0",
               {bus.busy, bus.done, bus.bout, bus.ovf, bus.diff});
    end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d want=0", seen);
    end
    run_op(16'h00FF, 16'h000F, 1'b0, got, lat, bc);
    checks++;
    if (got !== {2'b00, 16'h00F0} || lat !== 5) begin
      errors++;
      $display("FAIL after_abort got=%h lat=%0d want=%h lat=5",
               got, lat, {2'b00, 16'h00F0});
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] got, exp_v;
    int lat, bc, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op(ra, rb, rc, got, lat, bc);
      exp_v = model(ra, rb, rc);
      checks++;
      if (got !== exp_v || lat !== 5) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_%0d a=%h b=%h bin=%b got=%h lat=%0d want=%h",
                   i, ra, rb, rc, got, lat, exp_v);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_exp = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
